// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-ported data memory: IDLE grants, SERVE drives the memory, DONE acknowledges.
// Optional bounds check on the latched address is enabled by defining DMEM_ARB_BOUNDS_CHECK_EN (adds the err output).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner,
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    output logic              err,
`endif
    output logic [1:0]        dbg_state
);

    // Handshake: a master holds req until it sees its one-cycle ack; a req
    // still high in the IDLE cycle after DONE starts a new transaction.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                we_q, we_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_b;
    logic                chk_en;
    logic                oor;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    assign chk_en = 1'b1;
`else
    assign chk_en = 1'b0;
`endif
    assign oor = chk_en & (addr_q >= DEPTH_A);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            we_q         <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            we_q         <= we_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        we_d         = we_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        grant_b      = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    // On a tie the port that did not win last time goes first.
                    grant_b      = b_req && (!a_req || !last_grant_q);
                    addr_d       = grant_b ? b_addr  : a_addr;
                    wdata_d      = grant_b ? b_wdata : a_wdata;
                    we_d         = grant_b ? b_we    : a_we;
                    owner_d      = grant_b;
                    last_grant_d = grant_b;
                    state_d      = SERVE;
                end
            end
            SERVE: begin
                // Sampled at the same edge the write commits, so a write returns the old word.
                rdata_d = oor ? '0 : mem_rdata;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = (state_q == SERVE) && we_q && !oor;
        a_ack     = (state_q == DONE) && !owner_q;
        b_ack     = (state_q == DONE) && owner_q;
        a_rdata   = a_ack ? rdata_q : '0;
        b_rdata   = b_ack ? rdata_q : '0;
        busy      = (state_q != IDLE);
        owner     = owner_q;
        dbg_state = state_q;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        err       = (state_q == DONE) && oor;
`endif
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 100-word memory model; a monitor
// pops expected {err, port, rdata} entries on every ack.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int EW = DW + 2;

    logic          clk;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy, owner;
    logic          err_w;
    logic [1:0]    dbg_state;

    logic [DW-1:0] mem [0:99];
    logic [EW-1:0] exp_q [$];
    int            checks = 0;
    int            errors = 0;
    int            we_cnt = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner),
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        .err       (err_w),
`endif
        .dbg_state (dbg_state)
    );

`ifndef DMEM_ARB_BOUNDS_CHECK_EN
    assign err_w = 1'b0;
`endif

    // clock / reset-cleared memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 100) ? mem[mem_addr[6:0]] : '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 100; i++) mem[i] <= '0;
        end else if (mem_we && (mem_addr < 100)) begin
            mem[mem_addr[6:0]] <= mem_wdata;
        end
    end

    always @(negedge clk) if (mem_we) we_cnt++;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic port, input logic [DW-1:0] rdata, input logic e);
        exp_q.push_back({e, port, rdata});
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            if (a_ack || b_ack) begin
                check("ack_onehot", 32'(a_ack & b_ack), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack a_ack=%0b b_ack=%0b expected no ack", a_ack, b_ack);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_port", 32'(b_ack), 32'(e[DW]));
                    check("ack_rdata", b_ack ? b_rdata : a_rdata, e[DW-1:0]);
                    check("ack_err", 32'(err_w), 32'(e[DW+1]));
                end
            end else if (err_w) begin
                check("err_without_ack", 32'(err_w), 32'd0);
            end
        end
    end

    // driver tasks
    task automatic wait_ack(input logic port, input int lat_exp, input bit scramble);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (scramble && n == 1) begin
                a_addr = ~a_addr; a_we = ~a_we; a_wdata = ~a_wdata;
                b_addr = ~b_addr; b_we = ~b_we; b_wdata = ~b_wdata;
            end
            if (port ? b_ack : a_ack) seen = 1;
        end
        check("ack_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("ack_latency", n, lat_exp);
            check("owner", 32'(owner), 32'(port));
            check("busy_done", 32'(busy), 32'd1);
            check("dbg_state_done", 32'(dbg_state), 32'd2);
        end
        if (port) b_req = 1'b0; else a_req = 1'b0;
    endtask

    task automatic access(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                          input logic exp_err, input bit scramble);
        @(negedge clk);
        push_exp(port, exp_rdata, exp_err);
        if (port) begin
            b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
        end
        wait_ack(port, 2, scramble);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout reached without finishing");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        int acks, cyc;
        int t [3];
        logic who [3];

        rst = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd9; a_wdata = 32'h99;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

        // reset held with a pending write
        repeat (4) begin
            @(negedge clk);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_a_ack", 32'(a_ack), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_mem_addr", mem_addr, 32'd0);
        end
        check("rst_owner", 32'(owner), 32'd0);
        push_exp(1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        wait_ack(1'b0, 2, 1'b0);
        access(1'b0, 1'b0, 32'd9, 32'd0, 32'h99, 1'b0, 1'b0);

        // port A write then read, with inputs scrambled after grant on the read
        w0 = we_cnt;
        access(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
        check("write_we_pulses", we_cnt - w0, 32'd1);
        check("mem_addr_hold", mem_addr, 32'd5);
        w0 = we_cnt;
        access(1'b0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);
        check("read_we_pulses", we_cnt - w0, 32'd0);

        // simultaneous requests right after reset: A, B, A
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        a_we = 1'b1; a_addr = 32'd1; a_wdata = 32'h11; a_req = 1'b1;
        b_we = 1'b1; b_addr = 32'd2; b_wdata = 32'h22; b_req = 1'b1;
        push_exp(1'b0, 32'd0, 1'b0);
        push_exp(1'b1, 32'd0, 1'b0);
        push_exp(1'b0, 32'h11, 1'b0);
        acks = 0; cyc = 0;
        while (acks < 3 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (a_ack || b_ack) begin
                t[acks] = cyc;
                who[acks] = b_ack;
                acks++;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        check("tie_ack_count", acks, 32'd3);
        if (acks == 3) begin
            check("tie_first_latency", t[0], 32'd2);
            check("tie_spacing_1", t[1] - t[0], 32'd3);
            check("tie_spacing_2", t[2] - t[1], 32'd3);
            check("tie_order_0", 32'(who[0]), 32'd0);
            check("tie_order_1", 32'(who[1]), 32'd1);
            check("tie_order_2", 32'(who[2]), 32'd0);
        end
        access(1'b1, 1'b0, 32'd2, 32'd0, 32'h22, 1'b0, 1'b0);

        // read-during-write returns the old word
        access(1'b0, 1'b1, 32'd7, 32'h1, 32'd0, 1'b0, 1'b0);
        access(1'b1, 1'b1, 32'd7, 32'h2, 32'h1, 1'b0, 1'b0);
        access(1'b0, 1'b0, 32'd7, 32'd0, 32'h2, 1'b0, 1'b0);

        // reset during SERVE of a write
        @(negedge clk);
        a_we = 1'b1; a_addr = 32'd3; a_wdata = 32'hAA; a_req = 1'b1;
        @(negedge clk);
        check("serve_mem_we", 32'(mem_we), 32'd1);
        rst = 1'b0; a_req = 1'b0;
        #1;
        check("abort_mem_we", 32'(mem_we), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_ack", 32'(a_ack), 32'd0);
        end
        rst = 1'b1;
        access(1'b0, 1'b0, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);

        // out-of-range and last valid address
        w0 = we_cnt;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        access(1'b0, 1'b1, 32'd150, 32'h55, 32'd0, 1'b1, 1'b0);
        check("oor_we_pulses", we_cnt - w0, 32'd0);
`else
        access(1'b0, 1'b1, 32'd150, 32'h55, 32'd0, 1'b0, 1'b0);
        check("oor_we_pulses", we_cnt - w0, 32'd1);
`endif
        check("oor_mem_addr", mem_addr, 32'd150);
        w0 = we_cnt;
        access(1'b0, 1'b1, 32'd99, 32'h77, 32'd0, 1'b0, 1'b0);
        check("edge_we_pulses", we_cnt - w0, 32'd1);
        access(1'b1, 1'b0, 32'd99, 32'd0, 32'h77, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer that shares the single data memory (100 x 32-bit, one write port, combinational read) between two masters.
- Port A is the CPU load/store path; port B is the debug/loader path.
- Each access is a 3-cycle transaction: grant/latch, memory access, acknowledge.
- Round-robin arbitration applies on ties.
- Sits between the masters and the data memory's in/addr/we/out pins.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data word width.
- DEPTH, 100, number of valid memory words (used only by the optional bounds check).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- a_req  input  1  port A request; level, held until a_ack.
- a_we  input  1  port A write enable (1 = write, 0 = read).
- a_addr  input  ADDR_W  port A word address.
- a_wdata  input  DATA_W  port A write data.
- a_ack  output  1  port A one-cycle completion pulse.
- a_rdata  output  DATA_W  port A read data; valid while a_ack = 1.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as the port A signals, for port B.
- mem_addr  output  ADDR_W  to the memory address pin.
- mem_wdata  output  DATA_W  to the memory write-data pin.
- mem_we  output  1  to the memory write-enable pin (active high).
- mem_rdata  input  DATA_W  from the memory read-data pin.
- busy  output  1  high in SERVE and DONE.
- owner  output  1  0 = A, 1 = B; identifies the current or last granted port.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; latches 0; last_grant = B (so A wins the first tie).
- Reset mid-transaction aborts it: no write is committed after rst falls, and no ack is issued.
- FSM states: IDLE, SERVE, DONE.
- IDLE:
  - Neither req: stay in IDLE.
  - Only one req: grant that port.
  - Both req: grant the port that is not last_grant.
  - On grant: latch the winner's addr, wdata and we; set owner and last_grant; go to SERVE.
- SERVE (exactly 1 cycle):
  - mem_addr = latched addr; mem_wdata = latched wdata; mem_we = latched we.
  - At the closing edge: memory commits the write if mem_we; rdata_reg <= mem_rdata; go to DONE.
- DONE (exactly 1 cycle):
  - mem_we = 0; the granted port's ack = 1 and its rdata = rdata_reg; the other port's ack = 0.
  - Requests are ignored in this state; go to IDLE.
  - The master must drop req (or present a new request) while ack is high. A req still high in the following IDLE cycle is treated as a new request.
- Latency: req first sampled high in IDLE at edge N gives ack high in cycle N+2. Throughput is one access per 3 cycles.
- mem_we is high only in SERVE, and only when the latched we = 1. mem_addr/mem_wdata hold their latched values outside SERVE.
- Read in a write transaction: rdata returns mem_rdata sampled during SERVE, i.e. the old word, because the write commits at the same edge.
- Requester inputs changing after grant have no effect on the transaction in flight.
- Starvation-free: with both ports continuously requesting, grants strictly alternate A, B, A, B...
- Address is passed through unmodified; no wrap-around.

Optional Feature:
- Macro: DMEM_ARB_BOUNDS_CHECK_EN.
- When defined:
  - Adds output err (1 bit, reset 0).
  - If the latched addr >= DEPTH: mem_we is forced to 0 in SERVE; rdata_reg captures 0; err = 1 only during DONE, alongside the normal ack.
  - In-range accesses behave identically to the undefined case.
- When undefined:
  - No err port.
  - Out-of-range addresses are passed to the memory unchanged.

Test Plan:
- Reset: hold rst = 0 with a_req = 1 and a_we = 1 -> mem_we = 0 and a_ack = 0 throughout. Release rst -> first ack arrives exactly 2 cycles after the first sampling edge.
- Port A write then read: write addr 5, data 0xDEADBEEF -> mem_we high for 1 cycle, a_ack in cycle N+2. Then read addr 5 -> a_rdata = 0xDEADBEEF with a_ack.
- Simultaneous requests from reset: A writes addr 1 = 0x11, B writes addr 2 = 0x22, both held -> A is granted first, B second, acks 3 cycles apart. Continued requests alternate A, B, A.
- Read-during-write: preload addr 7 = 0x1; B writes addr 7 = 0x2 -> b_rdata = 0x1 at ack. A subsequent read of addr 7 returns 0x2.
- Mid-transaction reset: assert rst = 0 during SERVE of a write to addr 3 = 0xAA -> no ack issued; after reset, addr 3 reads 0 (memory cleared).
- With DMEM_ARB_BOUNDS_CHECK_EN: A writes addr 150 = 0x55 -> mem_we stays 0, a_ack = 1 with err = 1, a_rdata = 0. Addr 99 -> err = 0 and the write succeeds.
